id_stage: RTL

//  MIPS decode stage. Consumes the IF/ID instruction word, reads the register file,

---
 rtl/id_stage_pkg.sv | 50 +++++
 rtl/id_stage_register_file.sv | 65 ++++++
 rtl/id_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the MIPS decode stage: widths, instruction field
// positions, opcode constants and the ID/EX pipeline register payload.
package id_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned IMM_W    = 16;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;

  typedef struct packed {
    logic [DATA_W-1:0]  dato_rs;
    logic [DATA_W-1:0]  dato_rt;
    logic [DATA_W-1:0]  inmediato;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [ADDR_W-1:0]  rd;
    logic [SHAMT_W-1:0] shamt;
    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  pc_mas4;
    logic               valid;
  } id_ex_t;

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: one WB write port, two write-bypassed read ports and
// an unbypassed debug read port. R0 is hardwired to zero.
module id_stage_register_file
  import id_stage_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_dir,
  input  logic [DATA_W-1:0] i_wr_dato,
  input  logic [ADDR_W-1:0] i_rd_dir_a,
  input  logic [ADDR_W-1:0] i_rd_dir_b,
  input  logic [ADDR_W-1:0] i_debug_dir,
  output logic [DATA_W-1:0] o_rd_dato_a,
  output logic [DATA_W-1:0] o_rd_dato_b,
  output logic [DATA_W-1:0] o_debug_dato
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              bypass_a;
  logic              bypass_b;

  always_comb begin
    regs_d = regs_q;
    if (i_wr_en && i_enable && (i_wr_dir != '0)) begin
      regs_d[i_wr_dir] = i_wr_dato;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-then-read: a WB write in this cycle is visible to the decode reads
  assign bypass_a = i_wr_en && (i_wr_dir == i_rd_dir_a) && (i_rd_dir_a != '0);
  assign bypass_b = i_wr_en && (i_wr_dir == i_rd_dir_b) && (i_rd_dir_b != '0);

  always_comb begin
    o_rd_dato_a  = '0;
    o_rd_dato_b  = '0;
    o_debug_dato = '0;
    if (bypass_a) begin
      o_rd_dato_a = i_wr_dato;
    end else if (i_rd_dir_a != '0) begin
      o_rd_dato_a = regs_q[i_rd_dir_a];
    end
    if (bypass_b) begin
      o_rd_dato_b = i_wr_dato;
    end else if (i_rd_dir_b != '0) begin
      o_rd_dato_b = regs_q[i_rd_dir_b];
    end
    if (i_debug_dir != '0) begin
      o_debug_dato = regs_q[i_debug_dir];
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: register read, immediate extension, BEQ/BNE resolution
// and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [31:0]       i_instruccion,
  input  logic [31:0]       i_pc_mas4,
  input  logic              i_valid,
  input  logic              i_wb_reg_write,
  input  logic [4:0]        i_wb_dir,
  input  logic [31:0]       i_wb_dato,
  input  logic [4:0]        i_debug_dir,
  output logic [31:0]       o_debug_dato,
  output logic              o_branch_taken,
  output logic [31:0]       o_branch_dest,
  output logic [31:0]       o_dato_rs,
  output logic [31:0]       o_dato_rt,
  output logic [31:0]       o_inmediato,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_opcode,
  output logic [5:0]        o_funct,
  output logic [31:0]       o_pc_mas4,
  output logic              o_valid
);

  logic [OP_W-1:0]    opcode;
  logic [ADDR_W-1:0]  rs;
  logic [ADDR_W-1:0]  rt;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  dato_rs;
  logic [DATA_W-1:0]  dato_rt;
  logic [DATA_W-1:0]  imm_sext;
  logic [DATA_W-1:0]  imm_ext;
  logic               branch_cond;
  id_ex_t             id_ex_q;
  id_ex_t             id_ex_d;

  assign opcode = i_instruccion[OPCODE_MSB:OPCODE_LSB];
  assign rs     = i_instruccion[RS_MSB:RS_LSB];
  assign rt     = i_instruccion[RT_MSB:RT_LSB];
  assign imm    = i_instruccion[IMM_MSB:IMM_LSB];

  id_stage_register_file u_register_file (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_wr_en      (i_wb_reg_write),
    .i_wr_dir     (i_wb_dir),
    .i_wr_dato    (i_wb_dato),
    .i_rd_dir_a   (rs),
    .i_rd_dir_b   (rt),
    .i_debug_dir  (i_debug_dir),
    .o_rd_dato_a  (dato_rs),
    .o_rd_dato_b  (dato_rt),
    .o_debug_dato (o_debug_dato)
  );

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  // Logical immediates zero-extend, LUI shifts into the upper half
  always_comb begin
    imm_ext = imm_sext;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_LUI:                   imm_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:                  imm_ext = imm_sext;
    endcase
  end

  always_comb begin
    branch_cond = 1'b0;
    if (opcode == OP_BEQ) begin
      branch_cond = (dato_rs == dato_rt);
    end else if (opcode == OP_BNE) begin
      branch_cond = (dato_rs != dato_rt);
    end
  end

  assign o_branch_taken = branch_cond && i_valid && i_enable && !i_stall && !i_flush;
  assign o_branch_dest  = i_pc_mas4 + {imm_sext[DATA_W-3:0], 2'b00};

  // Freeze holds everything; flush/stall inject a bubble; otherwise load
  always_comb begin
    id_ex_d = id_ex_q;
    if (i_enable) begin
      if (i_flush || i_stall) begin
        id_ex_d = '0;
      end else begin
        id_ex_d.dato_rs   = dato_rs;
        id_ex_d.dato_rt   = dato_rt;
        id_ex_d.inmediato = imm_ext;
        id_ex_d.rs        = rs;
        id_ex_d.rt        = rt;
        id_ex_d.rd        = i_instruccion[RD_MSB:RD_LSB];
        id_ex_d.shamt     = i_instruccion[SHAMT_MSB:SHAMT_LSB];
        id_ex_d.opcode    = opcode;
        id_ex_d.funct     = i_instruccion[FUNCT_MSB:FUNCT_LSB];
        id_ex_d.pc_mas4   = i_pc_mas4;
        id_ex_d.valid     = i_valid;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign o_dato_rs   = id_ex_q.dato_rs;
  assign o_dato_rt   = id_ex_q.dato_rt;
  assign o_inmediato = id_ex_q.inmediato;
  assign o_rs        = id_ex_q.rs;
  assign o_rt        = id_ex_q.rt;
  assign o_rd        = id_ex_q.rd;
  assign o_shamt     = id_ex_q.shamt;
  assign o_opcode    = id_ex_q.opcode;
  assign o_funct     = id_ex_q.funct;
  assign o_pc_mas4   = id_ex_q.pc_mas4;
  assign o_valid     = id_ex_q.valid;

endmodule
